// File: rtl/sa_autosa_sdp_core_unpack_if.sv
// Handshake bundle for the SDP core narrow-to-wide unpack stage.
// Carries the narrow input beat channel and the wide output word channel.
// The inp_last signal exists only when AUTOSA_SDP_UNPACK_LAST_EN is defined.
//   slave  : the unpack core (consumes narrow beats, produces wide words)
//   master : the surrounding logic (produces narrow beats, consumes wide words)
interface sa_autosa_sdp_core_unpack_if #(
    parameter int IW = 128,
    parameter int OW = 512
);
    logic          inp_pvld;
    logic          inp_prdy;
    logic [IW-1:0] inp_data;
`ifdef AUTOSA_SDP_UNPACK_LAST_EN
    logic          inp_last;
`endif
    logic          out_pvld;
    logic          out_prdy;
    logic [OW-1:0] out_data;

`ifdef AUTOSA_SDP_UNPACK_LAST_EN
    modport slave (
        input  inp_pvld, inp_data, inp_last, out_prdy,
        output inp_prdy, out_pvld, out_data
    );

    modport master (
        output inp_pvld, inp_data, inp_last, out_prdy,
        input  inp_prdy, out_pvld, out_data
    );
`else
    modport slave (
        input  inp_pvld, inp_data, out_prdy,
        output inp_prdy, out_pvld, out_data
    );

    modport master (
        output inp_pvld, inp_data, out_prdy,
        input  inp_prdy, out_pvld, out_data
    );
`endif
endinterface

// File: rtl/sa_autosa_sdp_core_unpack.sv
// SDP core width up-converter: gathers RATIO narrow IW-bit beats into one
// registered OW-bit word, beat 0 in the least-significant segment.
// Optional early-flush marker inp_last is enabled by AUTOSA_SDP_UNPACK_LAST_EN.
module sa_autosa_sdp_core_unpack #(
    parameter int IW    = 128,
    parameter int OW    = 512,
    parameter int RATIO = OW / IW
) (
    input  logic                         autosa_core_clk,
    input  logic                         autosa_core_rstn,
    sa_autosa_sdp_core_unpack_if.slave   bus
);

    localparam logic [3:0] LAST_SEG = 4'(RATIO - 1);

    // Only power-of-two ratios up to 16 fit the 4-bit segment counter.
    generate
        if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8 || RATIO == 16)) begin : g_bad_ratio
            $error("sa_autosa_sdp_core_unpack: RATIO must be 1, 2, 4, 8 or 16");
        end
        if (OW != RATIO * IW) begin : g_bad_width
            $error("sa_autosa_sdp_core_unpack: OW must equal RATIO*IW");
        end
    endgenerate

    logic          out_pvld_q;
    logic          out_pvld_d;
    logic [3:0]    seg_cnt_q;
    logic [3:0]    seg_cnt_d;
    logic [OW-1:0] data_q;
    logic [OW-1:0] data_d;

    logic          inp_acc;
    logic          out_acc;
    logic          flush;
    logic          word_done;

    // A held word stalls input until the downstream takes it; take and accept may coincide.
    assign bus.inp_prdy = !out_pvld_q || bus.out_prdy;
    assign inp_acc      = bus.inp_pvld && bus.inp_prdy;
    assign out_acc      = out_pvld_q && bus.out_prdy;

`ifdef AUTOSA_SDP_UNPACK_LAST_EN
    assign flush = bus.inp_last;
`else
    assign flush = 1'b0;
`endif

    assign word_done = (seg_cnt_q == LAST_SEG) || flush;

    assign bus.out_pvld = out_pvld_q;
    assign bus.out_data = data_q;

    // Next-state: write the accepted beat into its segment, advance the counter, raise valid on completion.
    always_comb begin
        data_d     = data_q;
        seg_cnt_d  = seg_cnt_q;
        out_pvld_d = out_pvld_q;

        if (out_acc) begin
            out_pvld_d = 1'b0;
        end

        if (inp_acc) begin
            if (seg_cnt_q == 4'd0) begin
                data_d = '0;
            end
            for (int k = 0; k < RATIO; k++) begin
                if (seg_cnt_q == 4'(k)) begin
                    data_d[k*IW +: IW] = bus.inp_data;
                end
            end
            if (word_done) begin
                seg_cnt_d  = 4'd0;
                out_pvld_d = 1'b1;
            end else begin
                seg_cnt_d  = seg_cnt_q + 4'd1;
            end
        end
    end

    // State registers; reset drops any partial word immediately.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            out_pvld_q <= 1'b0;
            seg_cnt_q  <= 4'd0;
            data_q     <= '0;
        end else begin
            out_pvld_q <= out_pvld_d;
            seg_cnt_q  <= seg_cnt_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_sa_autosa_sdp_core_unpack.sv
// Self-checking bench for sa_autosa_sdp_core_unpack: a RATIO=4 instance driven
// from a vector table plus hand-written corner sequences, and a RATIO=1 instance.
module tb_sa_autosa_sdp_core_unpack;

    logic clk;
    logic rstn;

    int n_checks;
    int n_fail;

    sa_autosa_sdp_core_unpack_if #(.IW(128), .OW(512)) bus4 ();
    sa_autosa_sdp_core_unpack_if #(.IW(128), .OW(128)) bus1 ();

    sa_autosa_sdp_core_unpack #(.IW(128), .OW(512)) dut4 (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .bus              (bus4)
    );

    sa_autosa_sdp_core_unpack #(.IW(128), .OW(128)) dut1 (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .bus              (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         pvld;
        logic [127:0] data;
        logic         oprdy;
        logic         exp_iprdy;
        logic         exp_opvld;
        logic [511:0] exp_odata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [127:0] beat(input logic [7:0] tag, input int k);
        logic [31:0] w;
        w = {tag, 8'h00, 16'(k)};
        return {4{w}};
    endfunction

    function automatic logic [511:0] word4(input logic [127:0] s3, input logic [127:0] s2,
                                           input logic [127:0] s1, input logic [127:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic applyStimulus(input logic pvld, input logic [127:0] data, input logic oprdy);
        bus4.inp_pvld = pvld;
        bus4.inp_data = data;
        bus4.out_prdy = oprdy;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic step4(input logic pvld, input logic [127:0] data, input logic oprdy);
        @(negedge clk);
        applyStimulus(pvld, data, oprdy);
        #1;
    endtask

    initial begin
        logic [511:0] w;
        logic [511:0] word_a;
        logic [511:0] word_f;
        int r;
        int n;
        int base;

        n_checks = 0;
        n_fail   = 0;
        rstn = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        bus1.inp_pvld = 1'b0;
        bus1.inp_data = '0;
        bus1.out_prdy = 1'b0;
`ifdef AUTOSA_SDP_UNPACK_LAST_EN
        bus4.inp_last = 1'b0;
        bus1.inp_last = 1'b0;
`endif

        // Basic four-beat word followed by a 16-beat continuous stream
        word_a = word4(rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11));
        vecs.push_back('{"rst_state",  1'b1, rep(8'h11), 1'b1, 1'b1, 1'b0, 512'h0});
        vecs.push_back('{"beat1",      1'b1, rep(8'h22), 1'b1, 1'b1, 1'b0, word4('0, '0, '0, rep(8'h11))});
        vecs.push_back('{"beat2",      1'b1, rep(8'h33), 1'b1, 1'b1, 1'b0, word4('0, '0, rep(8'h22), rep(8'h11))});
        vecs.push_back('{"beat3",      1'b1, rep(8'h44), 1'b1, 1'b1, 1'b0, word4('0, rep(8'h33), rep(8'h22), rep(8'h11))});
        vecs.push_back('{"word_a",     1'b0, '0,         1'b1, 1'b1, 1'b1, word_a});
        vecs.push_back('{"word_a_gone",1'b0, '0,         1'b1, 1'b1, 1'b0, word_a});
        for (int j = 0; j <= 16; j++) begin
            if (j == 0) begin
                w = word_a;
            end else begin
                r    = j % 4;
                n    = (r == 0) ? 4 : r;
                base = j - n;
                w    = '0;
                for (int i = 0; i < n; i++) begin
                    w[i*128 +: 128] = beat(8'hE0, base + i);
                end
            end
            vecs.push_back('{$sformatf("stream_%0d", j), (j < 16), beat(8'hE0, j), 1'b1, 1'b1,
                             (j > 0 && j % 4 == 0), w});
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[v]) begin
            step4(vecs[v].pvld, vecs[v].data, vecs[v].oprdy);
            checkOutput({vecs[v].name, "_inp_prdy"}, 512'(bus4.inp_prdy), 512'(vecs[v].exp_iprdy));
            checkOutput({vecs[v].name, "_out_pvld"}, 512'(bus4.out_pvld), 512'(vecs[v].exp_opvld));
            checkOutput({vecs[v].name, "_out_data"}, bus4.out_data, vecs[v].exp_odata);
        end

        // Backpressure: completed word held for 5 cycles, then take and accept together
        word_f = word4(beat(8'hF0, 3), beat(8'hF0, 2), beat(8'hF0, 1), beat(8'hF0, 0));
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, beat(8'hF0, i), 1'b0);
            checkOutput("hold_fill_prdy", 512'(bus4.inp_prdy), 512'd1);
        end
        for (int c = 0; c < 5; c++) begin
            step4(1'b1, beat(8'hA0, 0), 1'b0);
            checkOutput("hold_inp_prdy", 512'(bus4.inp_prdy), 512'd0);
            checkOutput("hold_out_pvld", 512'(bus4.out_pvld), 512'd1);
            checkOutput("hold_out_data", bus4.out_data, word_f);
        end
        step4(1'b1, beat(8'hA0, 0), 1'b1);
        checkOutput("take_inp_prdy", 512'(bus4.inp_prdy), 512'd1);
        checkOutput("take_out_data", bus4.out_data, word_f);
        step4(1'b1, beat(8'hA0, 1), 1'b1);
        checkOutput("after_take_pvld", 512'(bus4.out_pvld), 512'd0);
        checkOutput("after_take_data", bus4.out_data, word4('0, '0, '0, beat(8'hA0, 0)));
        step4(1'b1, beat(8'hA0, 2), 1'b1);
        step4(1'b1, beat(8'hA0, 3), 1'b1);
        step4(1'b1, beat(8'hC0, 0), 1'b1);
        checkOutput("word_g_pvld", 512'(bus4.out_pvld), 512'd1);
        checkOutput("word_g_data", bus4.out_data,
                    word4(beat(8'hA0, 3), beat(8'hA0, 2), beat(8'hA0, 1), beat(8'hA0, 0)));

        // Reset after two beats of a word, then a fresh word
        step4(1'b1, beat(8'hC0, 1), 1'b1);
        checkOutput("partial_data", bus4.out_data, word4('0, '0, '0, beat(8'hC0, 0)));
        step4(1'b0, '0, 1'b1);
        checkOutput("partial2_data", bus4.out_data, word4('0, '0, beat(8'hC0, 1), beat(8'hC0, 0)));
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_pvld", 512'(bus4.out_pvld), 512'd0);
        checkOutput("async_rst_data", bus4.out_data, 512'h0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, beat(8'hD0, i), 1'b1);
        end
        step4(1'b0, '0, 1'b1);
        checkOutput("fresh_pvld", 512'(bus4.out_pvld), 512'd1);
        checkOutput("fresh_data", bus4.out_data,
                    word4(beat(8'hD0, 3), beat(8'hD0, 2), beat(8'hD0, 1), beat(8'hD0, 0)));
        step4(1'b0, '0, 1'b1);
        checkOutput("fresh_gone_pvld", 512'(bus4.out_pvld), 512'd0);

`ifdef AUTOSA_SDP_UNPACK_LAST_EN
        // Early flush after two beats, then a normal four-beat word
        step4(1'b1, rep(8'hAA), 1'b1);
        step4(1'b1, rep(8'hBB), 1'b1);
        bus4.inp_last = 1'b1;
        @(negedge clk);
        bus4.inp_last = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        #1;
        checkOutput("last_pvld", 512'(bus4.out_pvld), 512'd1);
        checkOutput("last_data", bus4.out_data, word4('0, '0, rep(8'hBB), rep(8'hAA)));
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, beat(8'h90, i), 1'b1);
        end
        step4(1'b0, '0, 1'b1);
        checkOutput("post_last_pvld", 512'(bus4.out_pvld), 512'd1);
        checkOutput("post_last_data", bus4.out_data,
                    word4(beat(8'h90, 3), beat(8'h90, 2), beat(8'h90, 1), beat(8'h90, 0)));
`endif

        // RATIO=1 pass-through: every beat is a word, one cycle later
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus1.inp_pvld = 1'b1;
            bus1.inp_data = beat(8'h70, i);
            bus1.out_prdy = 1'b1;
            #1;
            checkOutput("r1_inp_prdy", 512'(bus1.inp_prdy), 512'd1);
            if (i > 0) begin
                checkOutput($sformatf("r1_pvld_%0d", i), 512'(bus1.out_pvld), 512'd1);
                checkOutput($sformatf("r1_data_%0d", i), 512'(bus1.out_data), 512'(beat(8'h70, i - 1)));
            end
        end
        @(negedge clk);
        bus1.inp_pvld = 1'b0;
        #1;
        checkOutput("r1_last_pvld", 512'(bus1.out_pvld), 512'd1);
        checkOutput("r1_last_data", 512'(bus1.out_data), 512'(beat(8'h70, 7)));
        @(negedge clk);
        #1;
        checkOutput("r1_idle_pvld", 512'(bus1.out_pvld), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
